node_info_ctrl: RTL and testbench
=================================

NODE_INFO_CTRL -- requirements
Module: node_info_ctrl

Interface
REQ-001 Parameter WORD_W SHALL be: default 16; width of every packet field and data output.
REQ-002 Parameter NODE_ID SHALL be: default 16'h000C; this node's ID.
REQ-003 Parameter LOWE_CNT SHALL be: default 4; consecutive-sample count for the low-energy filter; legal range >=1.
REQ-004 clk  input  1  SHALL be the single system clock.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 en  input  1  SHALL be the packet strobe; all packet fields are valid only when en=1.
REQ-007 pkt_type  input  3  SHALL encode: 000 HB, 001 CHE, 100 CHI (timeslot assign), 101 DATA, 110 SOS; all other codes are ignored.
REQ-008 dest_id, hops, timeslot, e_threshold  input  WORD_W each  SHALL carry the packet fields.
REQ-009 energy  input  WORD_W; energy_vld  input  1  SHALL be the sensor sample and its strobe.
REQ-010 q_in  input  WORD_W; q_vld  input  1  SHALL be the Q-value from the compute unit and its strobe.
REQ-011 Outputs SHALL be: my_node_id, hops_from_sink, my_q, my_timeslot, e_thresh (WORD_W each); role 1 (1=CH); low_e 1; state 3; recluster_pend 1.

Function
REQ-012 FSM SHALL have states IDLE=0, SETUP=1, CH=2, MEMBER=3, COMM=4; the state output SHALL show this encoding.
REQ-013 IDLE or COMM, en && HB: SHALL go to SETUP; latch hops and e_threshold; clear role, my_timeslot and recluster_pend.
REQ-014 SETUP, en && HB: if hops < hops_from_sink (unsigned), SHALL update hops_from_sink only; an equal or greater hops value, or a new e_threshold, SHALL be ignored.
REQ-015 SETUP, en && CHE && dest_id==NODE_ID: SHALL go to CH; role=1.
REQ-016 SETUP, en && CHI && dest_id==NODE_ID: SHALL go to MEMBER; my_timeslot<=timeslot; role=0.
REQ-017 SETUP, en && DATA: SHALL go to COMM with role=0 and my_timeslot=0 (unclustered node).
REQ-018 CH or MEMBER, en && DATA: SHALL go to COMM; role and my_timeslot held.
REQ-019 CH or MEMBER: CHE and CHI SHALL be ignored; HB SHALL be ignored unless recluster_pend=1, in which case it SHALL be handled as in REQ-013.
REQ-020 SOS with en=1 in any state except IDLE SHALL set recluster_pend=1; it clears only on HB acceptance or reset.
REQ-021 en=0, dest_id mismatch, or an unused pkt_type SHALL leave the state and all packet-derived registers unchanged.
REQ-022 my_q SHALL load q_in on q_vld in any state (1-cycle latency) and hold otherwise; q_vld is independent of en.
REQ-023 A sample is "low" iff energy_vld && energy < e_thresh (the latched value, unsigned); while e_thresh==0 no sample is low.
REQ-024 my_node_id SHALL equal NODE_ID combinationally; all other outputs SHALL be registered.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force state=IDLE, all registered outputs to 0 and the filter counter to 0.
REQ-026 rst asserted mid-operation SHALL discard all latched fields; the first HB after deassertion SHALL be accepted as in REQ-013.
REQ-027 rst deassertion is synchronous to clk (external synchroniser); the first clk edge after deassertion SHALL be functional.

Configuration
REQ-028 With NODE_INFO_LOWE_FILT_EN defined: a saturating counter SHALL count consecutive valid samples whose low-ness disagrees with low_e; an agreeing sample clears it; on reaching LOWE_CNT, low_e SHALL toggle and the counter SHALL clear, with low_e changing the cycle after the LOWE_CNT-th sample; cycles with energy_vld=0 SHALL not affect the counter.
REQ-029 With NODE_INFO_LOWE_FILT_EN undefined: low_e SHALL load the low-ness of each valid sample with 1-cycle latency; no counter is instantiated.

Verification
REQ-030 Reset, then HB hops=3 thr=100 -> state=1, hops_from_sink=3, e_thresh=100; then HB hops=5 -> hops stays 3; then HB hops=2 -> hops=2.
REQ-031 In SETUP: CHE dest=0x0007 -> no change; CHE dest=0x000C -> state=2, role=1.
REQ-032 In SETUP: CHI dest=0x000C ts=7 -> state=3, my_timeslot=7; DATA -> state=4; HB hops=4 -> state=1, role=0, my_timeslot=0.
REQ-033 In CH: HB -> ignored (state=2); SOS -> recluster_pend=1; HB hops=6 -> state=1, pend=0, hops=6.
REQ-034 FILT_EN, LOWE_CNT=4, thr=100: energy 90 x3 then 120 -> low_e=0; 90 x4 -> low_e=1 the cycle after the 4th sample; 120 x4 -> low_e=0.
REQ-035 In MEMBER with ts=7, assert rst between clock edges -> state=0, my_timeslot=0, role=0 before the next edge.

Source files
------------

// File: rtl/node_info_ctrl.sv
// Node information controller: tracks clustering role, hop count, timeslot and low-energy status.
// Optional build macro NODE_INFO_LOWE_FILT_EN adds a consecutive-sample hysteresis filter on low_e.
module node_info_ctrl #(
    parameter int unsigned       WORD_W   = 16,
    parameter logic [WORD_W-1:0] NODE_ID  = 16'h000C,
    parameter int unsigned       LOWE_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        pkt_type,
    input  logic [WORD_W-1:0] dest_id,
    input  logic [WORD_W-1:0] hops,
    input  logic [WORD_W-1:0] timeslot,
    input  logic [WORD_W-1:0] e_threshold,
    input  logic [WORD_W-1:0] energy,
    input  logic              energy_vld,
    input  logic [WORD_W-1:0] q_in,
    input  logic              q_vld,
    output logic [WORD_W-1:0] my_node_id,
    output logic [WORD_W-1:0] hops_from_sink,
    output logic [WORD_W-1:0] my_q,
    output logic [WORD_W-1:0] my_timeslot,
    output logic [WORD_W-1:0] e_thresh,
    output logic              role,
    output logic              low_e,
    output logic [2:0]        state,
    output logic              recluster_pend
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StCh     = 3'd2,
        StMember = 3'd3,
        StComm   = 3'd4
    } state_e;

    localparam logic [2:0] PktHb   = 3'b000;
    localparam logic [2:0] PktChe  = 3'b001;
    localparam logic [2:0] PktChi  = 3'b100;
    localparam logic [2:0] PktData = 3'b101;
    localparam logic [2:0] PktSos  = 3'b110;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] hops_q, hops_d;
    logic [WORD_W-1:0] thr_q, thr_d;
    logic [WORD_W-1:0] ts_q, ts_d;
    logic [WORD_W-1:0] q_q, q_d;
    logic              role_q, role_d;
    logic              pend_q, pend_d;
    logic              low_q, low_d;

    logic is_hb, is_che, is_chi, is_data, is_sos;
    logic hb_accept, sample_low;

    // CHE/CHI are addressed to a node; HB/DATA/SOS are broadcast.
    assign is_hb   = en && (pkt_type == PktHb);
    assign is_che  = en && (pkt_type == PktChe) && (dest_id == NODE_ID);
    assign is_chi  = en && (pkt_type == PktChi) && (dest_id == NODE_ID);
    assign is_data = en && (pkt_type == PktData);
    assign is_sos  = en && (pkt_type == PktSos);

    always_comb begin
        hb_accept = 1'b0;
        case (state_q)
            StIdle, StComm:  hb_accept = is_hb;
            StCh, StMember:  hb_accept = is_hb && pend_q;
            default:         hb_accept = 1'b0;
        endcase
    end

    // A zero threshold can never be exceeded from below, so no sample is low then.
    assign sample_low = energy_vld && (thr_q != '0) && (energy < thr_q);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StComm: begin
                if (hb_accept) state_d = StSetup;
            end
            StSetup: begin
                if (is_che) begin
                    state_d = StCh;
                end else if (is_chi) begin
                    state_d = StMember;
                end else if (is_data) begin
                    state_d = StComm;
                end
            end
            StCh, StMember: begin
                if (hb_accept) begin
                    state_d = StSetup;
                end else if (is_data) begin
                    state_d = StComm;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state values
    always_comb begin
        hops_d = hops_q;
        thr_d  = thr_q;
        ts_d   = ts_q;
        role_d = role_q;
        pend_d = pend_q;
        q_d    = q_vld ? q_in : q_q;

        if (hb_accept) begin
            hops_d = hops;
            thr_d  = e_threshold;
            ts_d   = '0;
            role_d = 1'b0;
            pend_d = 1'b0;
        end else if (is_sos && (state_q != StIdle)) begin
            pend_d = 1'b1;
        end

        if (state_q == StSetup) begin
            if (is_hb && (hops < hops_q)) begin
                hops_d = hops;
            end else if (is_che) begin
                role_d = 1'b1;
            end else if (is_chi) begin
                ts_d   = timeslot;
                role_d = 1'b0;
            end else if (is_data) begin
                ts_d   = '0;
                role_d = 1'b0;
            end
        end
    end

`ifdef NODE_INFO_LOWE_FILT_EN
    localparam int unsigned CntW = $clog2(LOWE_CNT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    // Flip low_e only after LOWE_CNT consecutive disagreeing samples.
    always_comb begin
        cnt_d = cnt_q;
        low_d = low_q;
        if (energy_vld) begin
            if (sample_low != low_q) begin
                if (cnt_inc == CntW'(LOWE_CNT)) begin
                    low_d = ~low_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        low_d = energy_vld ? sample_low : low_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hops_q <= '0;
            thr_q  <= '0;
            ts_q   <= '0;
            q_q    <= '0;
            role_q <= 1'b0;
            pend_q <= 1'b0;
            low_q  <= 1'b0;
        end else begin
            hops_q <= hops_d;
            thr_q  <= thr_d;
            ts_q   <= ts_d;
            q_q    <= q_d;
            role_q <= role_d;
            pend_q <= pend_d;
            low_q  <= low_d;
        end
    end

    assign my_node_id     = NODE_ID;
    assign hops_from_sink = hops_q;
    assign my_q           = q_q;
    assign my_timeslot    = ts_q;
    assign e_thresh       = thr_q;
    assign role           = role_q;
    assign low_e          = low_q;
    assign state          = state_q;
    assign recluster_pend = pend_q;

endmodule

// File: tb/tb_node_info_ctrl.sv
// Scoreboard bench for node_info_ctrl: directed packets push hand-computed snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_node_info_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  pkt_type;
    logic [15:0] dest_id, hops, timeslot, e_threshold, energy, q_in;
    logic        energy_vld, q_vld;
    logic [15:0] my_node_id, hops_from_sink, my_q, my_timeslot, e_thresh;
    logic        role, low_e, recluster_pend;
    logic [2:0]  state;

    node_info_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .pkt_type       (pkt_type),
        .dest_id        (dest_id),
        .hops           (hops),
        .timeslot       (timeslot),
        .e_threshold    (e_threshold),
        .energy         (energy),
        .energy_vld     (energy_vld),
        .q_in           (q_in),
        .q_vld          (q_vld),
        .my_node_id     (my_node_id),
        .hops_from_sink (hops_from_sink),
        .my_q           (my_q),
        .my_timeslot    (my_timeslot),
        .e_thresh       (e_thresh),
        .role           (role),
        .low_e          (low_e),
        .state          (state),
        .recluster_pend (recluster_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic        role;
        logic [15:0] hops;
        logic [15:0] ts;
        logic [15:0] thr;
        logic        pend;
        logic        low;
        logic [15:0] q;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [2:0]  e_st;
    logic        e_role, e_pend, e_low;
    logic [15:0] e_hops, e_ts, e_thr, e_q;

    task automatic chk(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, exp);
        end
    endtask

    // Monitor: one snapshot per falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("state", e.id, 16'(state), 16'(e.st));
            chk("role", e.id, 16'(role), 16'(e.role));
            chk("hops_from_sink", e.id, hops_from_sink, e.hops);
            chk("my_timeslot", e.id, my_timeslot, e.ts);
            chk("e_thresh", e.id, e_thresh, e.thr);
            chk("recluster_pend", e.id, 16'(recluster_pend), 16'(e.pend));
            chk("low_e", e.id, 16'(low_e), 16'(e.low));
            chk("my_q", e.id, my_q, e.q);
            chk("my_node_id", e.id, my_node_id, 16'h000C);
        end
    end

    task automatic push(input int id);
        exp_q.push_back('{id, e_st, e_role, e_hops, e_ts, e_thr, e_pend, e_low, e_q});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        en         = 1'b0;
        energy_vld = 1'b0;
        q_vld      = 1'b0;
    endtask

    task automatic pkt(input logic e, input logic [2:0] t, input logic [15:0] d,
                       input logic [15:0] h, input logic [15:0] ts, input logic [15:0] thr);
        @(negedge clk);
        en = e; pkt_type = t; dest_id = d; hops = h; timeslot = ts; e_threshold = thr;
        tick();
    endtask

    task automatic smp(input logic [15:0] ev);
        @(negedge clk);
        energy = ev;
        energy_vld = 1'b1;
        tick();
    endtask

    task automatic idle();
        @(negedge clk);
        tick();
    endtask

    task automatic zero_exp();
        e_st = 3'd0; e_role = 1'b0; e_pend = 1'b0; e_low = 1'b0;
        e_hops = '0; e_ts = '0; e_thr = '0; e_q = '0;
    endtask

    localparam logic [2:0] HB = 3'b000, CHE = 3'b001, CHI = 3'b100, DATA = 3'b101,
                           SOS = 3'b110, UNUSED = 3'b011;

    logic [15:0] eseq [13];
    logic        lseq [13];

    initial begin
        rst = 1'b1; en = 1'b0; pkt_type = '0; dest_id = '0; hops = '0; timeslot = '0;
        e_threshold = '0; energy = '0; energy_vld = 1'b0; q_in = '0; q_vld = 1'b0;
        zero_exp();
        #3;
        push(0);
        @(negedge clk);
        rst = 1'b0;

        // Zero threshold: even energy 0 is not low.
        smp(16'd0);                                 push(1);
        @(negedge clk); q_in = 16'h1234; q_vld = 1'b1; tick();
        e_q = 16'h1234;                             push(2);

        pkt(1, HB, 0, 3, 0, 100);   e_st = 1; e_hops = 3; e_thr = 100;  push(3);
        pkt(1, HB, 0, 5, 0, 200);                                      push(4);
        pkt(1, HB, 0, 2, 0, 300);   e_hops = 2;                        push(5);
        pkt(1, CHE, 16'h0007, 0, 0, 0);                                push(6);
        pkt(0, CHE, 16'h000C, 0, 0, 0);                                push(7);
        pkt(1, UNUSED, 16'h000C, 0, 0, 0);                             push(8);
        pkt(1, CHE, 16'h000C, 0, 0, 0); e_st = 2; e_role = 1;          push(9);
        pkt(1, HB, 0, 9, 0, 77);                                       push(10);
        pkt(1, CHI, 16'h000C, 0, 5, 0);                                push(11);
        pkt(1, SOS, 0, 0, 0, 0);    e_pend = 1;                        push(12);
        pkt(1, HB, 0, 6, 0, 50);
        e_st = 1; e_pend = 0; e_hops = 6; e_thr = 50; e_role = 0;      push(13);
        pkt(1, CHI, 16'h000C, 0, 7, 0); e_st = 3; e_ts = 7;            push(14);
        pkt(1, DATA, 0, 0, 0, 0);   e_st = 4;                          push(15);
        pkt(1, HB, 0, 4, 0, 100);   e_st = 1; e_ts = 0; e_hops = 4; e_thr = 100; push(16);
        pkt(1, SOS, 0, 0, 0, 0);    e_pend = 1;                        push(17);
        pkt(1, DATA, 0, 0, 0, 0);   e_st = 4;                          push(18);
        pkt(1, HB, 0, 8, 0, 100);   e_st = 1; e_pend = 0; e_hops = 8;  push(19);

        // Energy samples against thr=100; 16'hFFFF marks a cycle with no sample.
        eseq = '{90, 90, 90, 120, 90, 90, 16'hFFFF, 90, 90, 120, 120, 120, 120};
`ifdef NODE_INFO_LOWE_FILT_EN
        lseq = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
        lseq = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 13; i++) begin
            if (eseq[i] == 16'hFFFF) idle();
            else smp(eseq[i]);
            e_low = lseq[i];
            push(20 + i);
        end

        // Mid-operation asynchronous reset from MEMBER.
        pkt(1, CHI, 16'h000C, 0, 7, 0); e_st = 3; e_ts = 7;            push(40);
        idle();
        #1;
        rst = 1'b1;
        #1;
        zero_exp();                                                    push(41);
        @(negedge clk);
        rst = 1'b0;
        pkt(1, HB, 0, 2, 0, 40);    e_st = 1; e_hops = 2; e_thr = 40;  push(42);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
